apb_rr_master: RTL and testbench
================================

// Module: apb_rr_master
// PURPOSE
//  Shares one APB slave port (2048-word memory slave) among NREQ requesters.
//  Round-robin arbitration, APB master sequencing, per-transfer timeout.
//  Each requester sees a simple valid/done interface and never drives APB directly.
// PARAMETERS
//  NREQ     2   number of requesters (2..8)
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  16  max ACCESS cycles waiting for pready; 0 = timeout disabled
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst        in   1        asynchronous reset, active-low
//  req_valid  in   NREQ     request i pending; held until req_done[i]
//  req_write  in   NREQ     1=write, 0=read, per requester
//  req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW  packed write data, same packing
//  req_done   out  NREQ     one-cycle one-hot completion pulse
//  rsp_rdata  out  DW       read data of last completed read
//  rsp_err    out  1        error status of last completed transfer
//  busy       out  1        high in SETUP/ACCESS
//  psel       out  1        APB select
//  penable    out  1        APB enable
//  pwrite     out  1        APB direction
//  paddr      out  AW       APB address
//  pwdata     out  DW       APB write data
//  prdata     in   DW       APB read data
//  pready     in   1        APB ready
//  pslverr    in   1        APB slave error
// BEHAVIOUR
//  - Reset values (async, immediate): all outputs 0; state IDLE; RR pointer = NREQ-1; timeout count 0.
//  - All outputs are registered.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//  - IDLE:
//    - If any eligible req_valid, grant the first one in order ptr+1, ptr+2, ... (mod NREQ).
//    - Latch its write/addr/wdata; ptr <= granted index; go to SETUP.
//  - SETUP: psel=1, penable=0; always go to ACCESS next edge.
//  - ACCESS: psel=1, penable=1.
//    - pready=1: complete the transfer; go to IDLE, deasserting psel/penable.
//    - pready=0: stay in ACCESS; wait count +1.
//  - pwrite/paddr/pwdata are stable from SETUP through the last ACCESS cycle.
//  - Completion:
//    - req_done[g]=1 for exactly the cycle after the completing edge.
//    - rsp_err = pslverr.
//    - rsp_rdata = prdata on reads only; writes leave rsp_rdata unchanged.
//  - Timeout:
//    - If TIMEOUT>0 and wait count reaches TIMEOUT with pready still 0, end the transfer as if completed.
//    - rsp_err=1; rsp_rdata unchanged; return to IDLE.
//    - Wait count clears on entry to SETUP.
//  - Latency: request sampled at edge E0 -> SETUP after E0, ACCESS after E1.
//    - With pready=1, done is high after E2.
//    - Minimum 3 cycles per transfer plus 1 IDLE cycle between transfers.
//  - Eligibility: a requester whose req_done bit is high is masked from arbitration that cycle.
//    - Requester must drop req_valid then; if still high the following cycle, it is a new request.
//  - Simultaneous requests: strict RR.
//    - A continuously requesting requester waits at most NREQ-1 transfers.
//  - Requests arriving during SETUP/ACCESS wait; req_valid changes while not granted are ignored.
//  - Address range is not checked here; range errors come back from the slave via pslverr.
//  - Reset mid-transfer: bus released immediately; no req_done issued; transfer is lost.
// TESTING
//  1. Req0 read 0x10, pready=1, prdata=0xDEADBEEF
//     -> psel after E0, penable after E1, req_done=2'b01 after E2; rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2. Req0 and req1 both valid from reset, re-requesting after each done
//     -> grant order 0,1,0,1; never the same requester twice while the other waits.
//  3. Req1 write 0x20/0x12345678, pready low 3 ACCESS cycles
//     -> ACCESS lasts 4 cycles, paddr/pwdata stable, one req_done[1] pulse.
//  4. pready held 0, TIMEOUT=16
//     -> after 16 ACCESS cycles: req_done pulse, rsp_err=1, psel=0, rsp_rdata unchanged.
//  5. Write 0x900 with pslverr=1 at pready
//     -> rsp_err=1, rsp_rdata unchanged; next good read clears rsp_err to 0.
//  6. rst low during ACCESS
//     -> psel/penable/req_done 0 asynchronously; after release, req0 wins the first arbitration.

Source files
------------

// File: rtl/apb_rr_master.sv
// Round-robin arbiter and APB master sharing one slave port among NREQ requesters.
// Grant at E0, SETUP after E0, ACCESS after E1, req_done the cycle after completion; pready stalls ACCESS up to TIMEOUT cycles.
module apb_rr_master #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_done,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = PW + 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);
    localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]     addr_arr  [NREQ];
    logic [DW-1:0]     wdata_arr [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [SW-1:0]     shift_amt;
    logic [2*NREQ-1:0] rotated;
    logic              gnt_found;
    logic [PW-1:0]     gnt_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // Rotate so bit 0 is the requester just after the last grant; first set bit wins.
    always_comb begin
        eligible  = req_valid & ~req_done_q;
        shift_amt = {1'b0, ptr_q} + SW'(1);
        rotated   = {eligible, eligible} >> shift_amt;
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        for (int j = 0; j < NREQ; j++) begin
            if (!gnt_found && rotated[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(shift_amt) + j) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        wait_d      = wait_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_done_d  = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d  = S_SETUP;
                    ptr_d    = gnt_idx;
                    gnt_d    = gnt_idx;
                    wait_d   = '0;
                    psel_d   = 1'b1;
                    pwrite_d = req_write[gnt_idx];
                    paddr_d  = addr_arr[gnt_idx];
                    pwdata_d = wdata_arr[gnt_idx];
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (pready) begin
                    state_d           = S_IDLE;
                    psel_d            = 1'b0;
                    penable_d         = 1'b0;
                    req_done_d[gnt_q] = 1'b1;
                    rsp_err_d         = pslverr;
                    if (!pwrite_q) begin
                        rsp_rdata_d = prdata;
                    end
                end else if (TIMEOUT > 0 && wait_q == WAIT_LAST) begin
                    // Abandon the transfer; read data from the slave is not trusted.
                    state_d           = S_IDLE;
                    psel_d            = 1'b0;
                    penable_d         = 1'b0;
                    req_done_d[gnt_q] = 1'b1;
                    rsp_err_d         = 1'b1;
                end else if (TIMEOUT > 0) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_RST;
            gnt_q       <= '0;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_done_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_done_q  <= req_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign req_done  = req_done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: APB memory slave model, requester tasks and an expected-completion queue.
module tb_apb_rr_master;

    localparam int NREQ    = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   req_done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic [DW-1:0]   rdata;
        logic            err;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model_rdata;
    int            slv_wait = 0;
    bit            slv_hang = 0;
    logic [DW-1:0] mem [int];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Slave: pready after slv_wait stalled ACCESS cycles; words at 0x800 and above answer pslverr.
    initial begin
        int acc;
        acc = 0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                acc++;
                if (!slv_hang && acc > slv_wait) begin
                    pready  = 1'b1;
                    pslverr = (paddr >= 32'h800);
                    if (pwrite) begin
                        prdata = '0;
                        if (!pslverr) mem[int'(paddr)] = pwdata;
                    end else begin
                        prdata = mem.exists(int'(paddr)) ? mem[int'(paddr)] : (32'hBAD0_0000 ^ paddr);
                    end
                end else begin
                    pready = 1'b0; pslverr = 1'b0; prdata = 32'h5A5A_5A5A;
                end
            end else begin
                acc = 0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h5A5A_5A5A;
            end
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_done(input int budget, output logic ok, output int acc_cycles);
        ok = 1'b0;
        acc_cycles = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req_done != '0) begin
                ok = 1'b1;
                break;
            end
            if (psel && penable) acc_cycles++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({psel, penable, busy, rsp_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctl: got %b expected 0000", {psel, penable, busy, rsp_err});
        end
        checks++;
        if (req_done !== '0) begin
            failures++; $display("FAIL reset_done: got %b expected 00", req_done);
        end
        checks++;
        if (rsp_rdata !== '0) begin
            failures++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
        end
        checks++;
        if ({pwrite, paddr, pwdata} !== '0) begin
            failures++; $display("FAIL reset_bus: got %b/%h/%h expected zeros", pwrite, paddr, pwdata);
        end
        rst = 1'b1;
        model_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        exp_t e;
        mem[32'h10] = 32'hDEADBEEF;
        exp_q.push_back('{done: 2'b01, rdata: 32'hDEADBEEF, err: 1'b0});
        model_rdata = 32'hDEADBEEF;
        set_req(0, 1'b0, 32'h10, '0);
        @(negedge clk);
        checks++;
        if ({psel, penable, busy} !== 3'b101) begin
            failures++; $display("FAIL read_setup: psel/penable/busy got %b expected 101", {psel, penable, busy});
        end
        checks++;
        if (paddr !== 32'h10 || pwrite !== 1'b0) begin
            failures++; $display("FAIL read_addr: got %h/%b expected 00000010/0", paddr, pwrite);
        end
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            failures++; $display("FAIL read_access: got %b expected 11", {psel, penable});
        end
        @(negedge clk);
        pop_exp(e);
        checks++;
        if (req_done !== e.done) begin
            failures++; $display("FAIL read_done_latency: got %b expected %b", req_done, e.done);
        end
        req_valid[0] = 1'b0;
        checks++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++; $display("FAIL read_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
        end
        checks++;
        if ({psel, penable} !== 2'b00) begin
            failures++; $display("FAIL read_release: got %b expected 00", {psel, penable});
        end
        @(negedge clk);
        checks++;
        if (req_done !== '0) begin
            failures++; $display("FAIL read_done_pulse: got %b expected 00", req_done);
        end
    endtask

    task automatic test_rr();
        exp_t e;
        logic ok;
        int acc;
        int mptr;
        int ecnt[NREQ];
        int rcnt[NREQ];
        logic [NREQ-1:0] d;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_rdata = '0;
        for (int n = 0; n < 4; n++) begin
            mem[32'h100 + n] = 32'h1000_0000 + n;
            mem[32'h200 + n] = 32'h2000_0000 + n;
        end
        mptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            ecnt[i] = 0;
            rcnt[i] = 1;
        end
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (mptr + 1) % NREQ;
            mptr = g;
            exp_q.push_back('{done: NREQ'(1) << g,
                              rdata: ((g == 0) ? 32'h1000_0000 : 32'h2000_0000) + ecnt[g], err: 1'b0});
            ecnt[g]++;
        end
        set_req(0, 1'b0, 32'h100, '0);
        set_req(1, 1'b0, 32'h200, '0);
        for (int k = 0; k < 4; k++) begin
            wait_done(40, ok, acc);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL rr_wait: no req_done within 40 cycles (k=%0d) expected one", k);
            end
            pop_exp(e);
            checks++;
            if (req_done !== e.done) begin
                failures++; $display("FAIL rr_order: k=%0d got %b expected %b", k, req_done, e.done);
            end
            checks++;
            if (rsp_rdata !== e.rdata) begin
                failures++; $display("FAIL rr_rdata: k=%0d got %h expected %h", k, rsp_rdata, e.rdata);
            end
            model_rdata = e.rdata;
            d = req_done;
            req_valid = req_valid & ~d;
            if (k == 3) begin
                req_valid = '0;
            end else begin
                @(negedge clk);
                for (int i = 0; i < NREQ; i++) begin
                    if (d[i]) begin
                        set_req(i, 1'b0, ((i == 0) ? 32'h100 : 32'h200) + rcnt[i], '0);
                        rcnt[i]++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic ok;
        int acc;
        exp_q.push_back('{done: 2'b01, rdata: 32'hDEADBEEF, err: 1'b0});
        exp_q.push_back('{done: 2'b01, rdata: 32'hDEADBEEF, err: 1'b0});
        model_rdata = 32'hDEADBEEF;
        set_req(0, 1'b0, 32'h10, '0);
        wait_done(20, ok, acc);
        pop_exp(e);
        checks++;
        if (!ok || req_done !== e.done) begin
            failures++; $display("FAIL b2b_first: got %b expected %b", req_done, e.done);
        end
        @(negedge clk);
        checks++;
        if (psel !== 1'b0) begin
            failures++; $display("FAIL b2b_mask: psel got %b expected 0 (done requester masked)", psel);
        end
        @(negedge clk);
        checks++;
        if (psel !== 1'b1) begin
            failures++; $display("FAIL b2b_rerequest: psel got %b expected 1", psel);
        end
        wait_done(20, ok, acc);
        pop_exp(e);
        checks++;
        if (!ok || req_done !== e.done || rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL b2b_second: got %b/%h expected %b/%h", req_done, rsp_rdata, e.done, e.rdata);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        exp_t e;
        logic ok;
        logic stable;
        int acc;
        slv_wait = 3;
        exp_q.push_back('{done: 2'b10, rdata: model_rdata, err: 1'b0});
        set_req(1, 1'b1, 32'h20, 32'h12345678);
        ok = 1'b0; stable = 1'b1; acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_done != '0) begin
                ok = 1'b1;
                break;
            end
            if (psel && (paddr !== 32'h20 || pwdata !== 32'h12345678 || pwrite !== 1'b1)) stable = 1'b0;
            if (psel && penable) acc++;
        end
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wait_done: no req_done within 40 cycles expected one");
        end
        checks++;
        if (acc != 4) begin
            failures++; $display("FAIL wait_access_len: got %0d expected 4", acc);
        end
        checks++;
        if (!stable) begin
            failures++; $display("FAIL wait_stable: got unstable bus expected stable 00000020/12345678");
        end
        pop_exp(e);
        checks++;
        if (req_done !== e.done || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL wait_rsp: got %b/%b/%h expected %b/%b/%h",
                                 req_done, rsp_err, rsp_rdata, e.done, e.err, e.rdata);
        end
        req_valid[1] = 1'b0;
        slv_wait = 0;
        @(negedge clk);
        checks++;
        if (req_done !== '0) begin
            failures++; $display("FAIL wait_done_pulse: got %b expected 00", req_done);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic ok;
        int acc;
        slv_hang = 1'b1;
        exp_q.push_back('{done: 2'b01, rdata: model_rdata, err: 1'b1});
        set_req(0, 1'b0, 32'h30, '0);
        wait_done(60, ok, acc);
        checks++;
        if (!ok || acc != TIMEOUT) begin
            failures++; $display("FAIL timeout_len: done=%b access cycles got %0d expected %0d", ok, acc, TIMEOUT);
        end
        pop_exp(e);
        checks++;
        if (req_done !== e.done || rsp_err !== e.err) begin
            failures++; $display("FAIL timeout_rsp: got %b/%b expected %b/%b", req_done, rsp_err, e.done, e.err);
        end
        checks++;
        if (rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL timeout_rdata: got %h expected %h", rsp_rdata, e.rdata);
        end
        checks++;
        if (psel !== 1'b0) begin
            failures++; $display("FAIL timeout_psel: got %b expected 0", psel);
        end
        req_valid[0] = 1'b0;
        slv_hang = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slverr();
        exp_t e;
        logic ok;
        int acc;
        exp_q.push_back('{done: 2'b10, rdata: model_rdata, err: 1'b1});
        set_req(1, 1'b1, 32'h900, 32'hCAFEF00D);
        wait_done(20, ok, acc);
        pop_exp(e);
        checks++;
        if (!ok || req_done !== e.done || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL slverr_write: got %b/%b/%h expected %b/%b/%h",
                                 req_done, rsp_err, rsp_rdata, e.done, e.err, e.rdata);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
        exp_q.push_back('{done: 2'b01, rdata: 32'h12345678, err: 1'b0});
        model_rdata = 32'h12345678;
        set_req(0, 1'b0, 32'h20, '0);
        wait_done(20, ok, acc);
        pop_exp(e);
        checks++;
        if (!ok || req_done !== e.done || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL slverr_readback: got %b/%b/%h expected %b/%b/%h",
                                 req_done, rsp_err, rsp_rdata, e.done, e.err, e.rdata);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic ok;
        logic in_access;
        int acc;
        mem[32'h40] = 32'h4444_4444;
        slv_hang = 1'b1;
        set_req(1, 1'b0, 32'h40, '0);
        in_access = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (psel && penable) begin
                in_access = 1'b1;
                break;
            end
        end
        checks++;
        if (!in_access) begin
            failures++; $display("FAIL rstmid_access: never reached ACCESS expected ACCESS");
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({psel, penable, busy, req_done} !== 5'b0) begin
            failures++; $display("FAIL rstmid_async: got %b expected 00000", {psel, penable, busy, req_done});
        end
        set_req(0, 1'b0, 32'h10, '0);
        slv_hang = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_rdata = '0;
        exp_q.push_back('{done: 2'b01, rdata: 32'hDEADBEEF, err: 1'b0});
        exp_q.push_back('{done: 2'b10, rdata: 32'h4444_4444, err: 1'b0});
        wait_done(20, ok, acc);
        pop_exp(e);
        checks++;
        if (!ok || req_done !== e.done || rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL rstmid_first_grant: got %b/%h expected %b/%h", req_done, rsp_rdata, e.done, e.rdata);
        end
        req_valid[0] = 1'b0;
        wait_done(20, ok, acc);
        pop_exp(e);
        checks++;
        if (!ok || req_done !== e.done || rsp_rdata !== e.rdata) begin
            failures++; $display("FAIL rstmid_second: got %b/%h expected %b/%h", req_done, rsp_rdata, e.done, e.rdata);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
